// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like slave port between the instruction-fetch master
//   (inst_*) and the data master (data_*). It arbitrates address phases and
//   records the owner of every accepted transaction in an owner FIFO. Each
//   in-order slave response (sram_data_ok / sram_rdata) is then routed back
//   to the master that issued it.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   inst_*  (in)          inst master request: req, wr, size, addr, wstrb, wdata
//   inst_addr_ok (out)    inst address phase accepted this cycle
//   inst_data_ok (out)    inst response valid this cycle
//   inst_rdata   (out)    inst read data (valid with inst_data_ok)
//   data_*                data master, same shape as inst_*
//   sram_* (out)          request fields to the slave: req, wr, size, addr, wstrb, wdata
//   sram_addr_ok (in)     slave accepted the address phase
//   sram_data_ok (in)     slave response, in order
//   sram_rdata   (in)     slave read data
//   arb_err      (out)    sticky: a response arrived while no transaction was in flight
//
// Configuration
//   ARB_INST_CANCEL_EN    adds the inst_cancel input. While it is high, every
//                         in-flight inst transaction (including one accepted in
//                         that cycle) is marked discard. Its response is then
//                         popped without raising inst_data_ok.
//
// Parameter
//   MAX_OUTSTANDING       accepted-but-unanswered limit; power of 2, 1..8

module sram_like_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

`ifdef ARB_INST_CANCEL_EN
    input  logic        inst_cancel,
`endif

    output logic        sram_req,
    output logic        sram_wr,
    output logic [1:0]  sram_size,
    output logic [31:0] sram_addr,
    output logic [3:0]  sram_wstrb,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata,

    output logic        arb_err
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_t;

    lock_t                      lock_q, lock_d;
    logic [CW-1:0]              count_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] owner_q;     // 0 = inst, 1 = data
`ifdef ARB_INST_CANCEL_EN
    logic [MAX_OUTSTANDING-1:0] discard_q;
`endif

    logic grant_data, sel_req, fifo_full, fifo_empty;
    logic push, pop, head_owner, inst_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end

    always_comb begin
        grant_data   = 1'b0;
        lock_d       = lock_q;
        sel_req      = 1'b0;
        sram_req     = 1'b0;
        sram_wr      = 1'b0;
        sram_size    = '0;
        sram_addr    = '0;
        sram_wstrb   = '0;
        sram_wdata   = '0;
        push         = 1'b0;
        pop          = 1'b0;
        head_owner   = owner_q[rd_ptr_q];
        inst_fwd     = 1'b1;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
        fifo_empty = (count_q == '0);

        case (lock_q)
            LOCK_INST: grant_data = 1'b0;
            LOCK_DATA: grant_data = 1'b1;
            default:   grant_data = data_req;
        endcase

        sel_req = grant_data ? data_req : inst_req;
        if (grant_data) begin
            sram_wr    = data_wr;
            sram_size  = data_size;
            sram_addr  = data_addr;
            sram_wstrb = data_wstrb;
            sram_wdata = data_wdata;
        end else begin
            sram_wr    = inst_wr;
            sram_size  = inst_size;
            sram_addr  = inst_addr;
            sram_wstrb = inst_wstrb;
            sram_wdata = inst_wdata;
        end

        sram_req     = sel_req & ~fifo_full & ~reset;
        push         = sram_req & sram_addr_ok;
        inst_addr_ok = push & ~grant_data;
        data_addr_ok = push &  grant_data;

        // A stalled request pins the grant until it is accepted. While the
        // FIFO is full sram_req is low, so the lock is left untouched.
        if (push) begin
            lock_d = LOCK_NONE;
        end else if (sram_req) begin
            lock_d = grant_data ? LOCK_DATA : LOCK_INST;
        end

        pop = sram_data_ok & ~fifo_empty & ~reset;
`ifdef ARB_INST_CANCEL_EN
        // A head entry popped in the cancel cycle is in flight too, so it is dropped.
        inst_fwd = ~discard_q[rd_ptr_q] & ~inst_cancel;
`endif
        inst_data_ok = pop & ~head_owner & inst_fwd;
        data_data_ok = pop &  head_owner;
    end

    assign inst_rdata = sram_rdata;
    assign data_rdata = sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            owner_q  <= '0;
            arb_err  <= 1'b0;
`ifdef ARB_INST_CANCEL_EN
            discard_q <= '0;
`endif
        end else begin
`ifdef ARB_INST_CANCEL_EN
            if (inst_cancel) begin
                for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                    if (!owner_q[i]) discard_q[i] <= 1'b1;
                end
            end
`endif
            if (push) begin
                owner_q[wr_ptr_q] <= grant_data;
`ifdef ARB_INST_CANCEL_EN
                discard_q[wr_ptr_q] <= inst_cancel & ~grant_data;
`endif
                wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (sram_data_ok && fifo_empty) begin
                arb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter
//   Directed test of sram_like_arbiter with MAX_OUTSTANDING = 2.
//   The bench changes inputs 1 ns after each rising edge and samples outputs
//   on the falling edge.

module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_req, sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr, sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        sram_addr_ok, sram_data_ok;
    logic [31:0] sram_rdata;
    logic        arb_err;
`ifdef ARB_INST_CANCEL_EN
    logic        inst_cancel;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
`ifdef ARB_INST_CANCEL_EN
        .inst_cancel(inst_cancel),
`endif
        .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
        .sram_addr(sram_addr), .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
        .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
        .arb_err(arb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Expected per-cycle handshake outputs: {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    task automatic check_hs(input string tag, input logic [3:0] exp);
        check_eq(tag, 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = '0;
`ifdef ARB_INST_CANCEL_EN
        inst_cancel = 0;
`endif
        tick(); tick();

        // Reset dominates: nothing is issued or acknowledged even with everything asserted.
        inst_req = 1; data_req = 1; sram_addr_ok = 1; sram_data_ok = 1;
        sample();
        check_eq("rst_sram_req", 32'(sram_req), 32'd0);
        check_hs("rst_handshake", 4'b0000);
        check_eq("rst_arb_err", 32'(arb_err), 32'd0);
        tick();
        inst_req = 0; data_req = 0; sram_addr_ok = 0; sram_data_ok = 0;
        reset = 0;

        // Both request: data first, then inst.
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        sram_addr_ok = 1;
        sample();
        check_hs("both_data_first", 4'b0100);
        check_eq("both_sram_addr_d", sram_addr, 32'h0000_2000);
        check_eq("both_sram_wr_d", 32'(sram_wr), 32'd1);
        check_eq("both_sram_wdata_d", sram_wdata, 32'hDEAD_BEEF);
        tick();
        data_req = 0; data_wr = 0;
        sample();
        check_hs("both_inst_next", 4'b1000);
        check_eq("both_sram_addr_i", sram_addr, 32'h0000_1000);
        tick();
        inst_req = 0; sram_addr_ok = 0;
        sram_data_ok = 1; sram_rdata = 32'hAAAA_0001;
        sample();
        check_hs("both_resp1_data", 4'b0001);
        check_eq("both_resp1_rdata", data_rdata, 32'hAAAA_0001);
        tick();
        sram_rdata = 32'hAAAA_0002;
        sample();
        check_hs("both_resp2_inst", 4'b0010);
        check_eq("both_resp2_rdata", inst_rdata, 32'hAAAA_0002);
        tick();
        sram_data_ok = 0;

        // Data stalls 3 cycles; inst joins in cycle 2; grant stays with data.
        data_req = 1; data_addr = 32'h0000_3000;
        sample();
        check_eq("stall_c1_req", 32'(sram_req), 32'd1);
        check_hs("stall_c1_hs", 4'b0000);
        tick();
        inst_req = 1; inst_addr = 32'h0000_1004;
        sample();
        check_eq("stall_c2_addr", sram_addr, 32'h0000_3000);
        check_hs("stall_c2_hs", 4'b0000);
        tick();
        sample();
        check_eq("stall_c3_addr", sram_addr, 32'h0000_3000);
        tick();
        sram_addr_ok = 1;
        sample();
        check_hs("stall_c4_data_ok", 4'b0100);
        tick();
        data_req = 0;
        sample();
        check_hs("stall_c5_inst_ok", 4'b1000);
        check_eq("stall_c5_addr", sram_addr, 32'h0000_1004);
        tick();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        sample();
        check_hs("stall_resp_data", 4'b0001);
        tick();
        sample();
        check_hs("stall_resp_inst", 4'b0010);
        tick();
        sram_data_ok = 0;

        // Stalled inst keeps the grant even after data starts requesting.
        inst_req = 1; inst_addr = 32'h0000_1008;
        tick();
        data_req = 1; data_addr = 32'h0000_4000;
        sample();
        check_eq("lock_inst_addr", sram_addr, 32'h0000_1008);
        tick();
        sram_addr_ok = 1;
        sample();
        check_hs("lock_inst_accept", 4'b1000);
        tick();
        inst_req = 0;
        sample();
        check_hs("lock_then_data", 4'b0100);
        tick();
        data_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        sample();
        check_hs("lock_resp_inst", 4'b0010);
        tick();
        sample();
        check_hs("lock_resp_data", 4'b0001);
        tick();
        sram_data_ok = 0;

        // inst A then data B; responses are routed in order.
        inst_req = 1; inst_addr = 32'h0000_00A0; sram_addr_ok = 1;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_00B0;
        sample();
        check_hs("ab_data_accept", 4'b0100);
        tick();
        data_req = 0; sram_addr_ok = 0;
        sram_data_ok = 1; sram_rdata = 32'h1111_1111;
        sample();
        check_hs("ab_resp_a", 4'b0010);
        check_eq("ab_inst_rdata", inst_rdata, 32'h1111_1111);
        check_eq("ab_fanout_rdata", data_rdata, 32'h1111_1111);
        tick();
        sram_rdata = 32'h2222_2222;
        sample();
        check_hs("ab_resp_b", 4'b0001);
        check_eq("ab_data_rdata", data_rdata, 32'h2222_2222);
        tick();
        sram_data_ok = 0;

        // Fill to MAX_OUTSTANDING=2; third request blocked until a response.
        inst_req = 1; sram_addr_ok = 1;
        tick();
        sample();
        check_hs("full_second_accept", 4'b1000);
        tick();
        sample();
        check_eq("full_c3_req", 32'(sram_req), 32'd0);
        check_hs("full_c3_hs", 4'b0000);
        tick();
        sample();
        check_eq("full_c4_req", 32'(sram_req), 32'd0);
        tick();
        sram_data_ok = 1;
        sample();
        check_hs("full_pop_no_unblock", 4'b0010);
        check_eq("full_pop_req", 32'(sram_req), 32'd0);
        tick();
        sram_data_ok = 0;
        sample();
        check_eq("full_unblock_req", 32'(sram_req), 32'd1);
        check_hs("full_unblock_hs", 4'b1000);
        tick();
        inst_req = 0; sram_addr_ok = 0; sram_data_ok = 1;
        sample();
        check_hs("full_drain1", 4'b0010);
        tick();
        sample();
        check_hs("full_drain2", 4'b0010);
        tick();

        // Response with an empty FIFO: ignored, arb_err becomes sticky.
        sample();
        check_hs("empty_resp_ignored", 4'b0000);
        check_eq("empty_err_before", 32'(arb_err), 32'd0);
        tick();
        sram_data_ok = 0;
        sample();
        check_eq("empty_err_set", 32'(arb_err), 32'd1);
        tick(); tick();
        sample();
        check_eq("empty_err_held", 32'(arb_err), 32'd1);
        tick();
        reset = 1;
        tick();
        reset = 0;
        sample();
        check_eq("empty_err_cleared", 32'(arb_err), 32'd0);

`ifdef ARB_INST_CANCEL_EN
        // Two inst in flight, cancel, then a data read: inst responses dropped.
        tick();
        inst_req = 1; sram_addr_ok = 1;
        tick(); tick();
        inst_req = 0; inst_cancel = 1;
        tick();
        inst_cancel = 0; sram_data_ok = 1;
        sample();
        check_hs("cancel_drop1", 4'b0000);
        tick();
        data_req = 1; data_addr = 32'h0000_5000; sram_rdata = 32'h3333_3333;
        sample();
        check_hs("cancel_drop2_data_acc", 4'b0100);
        tick();
        data_req = 0; sram_addr_ok = 0;
        sample();
        check_hs("cancel_data_resp", 4'b0001);
        check_eq("cancel_data_rdata", data_rdata, 32'h3333_3333);
        tick();
        sram_data_ok = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
